// File: rtl/stream_unpacker.sv
// Unpacks a dense byte stream of length-prefixed records into one
// right-aligned record per cycle, with frame-aware error recovery.
module stream_unpacker #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned TKEEP_WIDTH = 32,
    parameter int unsigned LEN_WIDTH   = 6,
    parameter int unsigned BUF_BYTES   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [TKEEP_WIDTH-1:0] in_tkeep,
    input  logic                   in_tlast,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [LEN_WIDTH-1:0]   out_len,
    output logic [TKEEP_WIDTH-1:0] out_tkeep,
    output logic                   out_tlast,
    output logic                   err
);
    localparam int unsigned BUF_W  = BUF_BYTES * 8;
    localparam int unsigned FILL_W = $clog2(BUF_BYTES + 1);
    localparam logic [FILL_W-1:0] MAX_LEN_F = FILL_W'(TKEEP_WIDTH);
    localparam logic [8:0]        MAX_LEN_9 = 9'(TKEEP_WIDTH);

    typedef enum logic {RUN, DROP} state_e;

    state_e                   state_q, state_d;
    logic [BUF_W-1:0]         byte_buf_q, byte_buf_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic                     last_pend_q, last_pend_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [LEN_WIDTH-1:0]     out_len_q, out_len_d;
    logic [TKEEP_WIDTH-1:0]   out_tkeep_q, out_tkeep_d;
    logic                     out_tlast_q, out_tlast_d;
    logic                     err_q, err_d;

    logic                     run;
    logic                     have;
    logic                     accept;
    logic                     out_free;
    logic [7:0]               hdr;
    logic [8:0]               hdr9;
    logic [8:0]               need9;
    logic [8:0]               fill9;
    logic                     hdr_ok;
    logic                     hdr_bad;
    logic                     ext_slot;
    logic                     do_pad;
    logic                     do_rec;
    logic                     do_bad;
    logic                     do_trunc;
    logic                     rec_last;
    logic [FILL_W-1:0]        in_cnt;
    logic [FILL_W-1:0]        shift_amt;
    logic [FILL_W-1:0]        fill_mid;
    logic [BUF_W-1:0]         buf_mid;
    logic [BUF_W-1:0]         in_wide;
    logic [DATA_WIDTH-1:0]    rec_data;
    logic [TKEEP_WIDTH-1:0]   rec_keep;

    // Header decode and the per-cycle action; at most one of pad/rec/bad/trunc fires.
    always_comb begin
        run      = (state_q == RUN);
        have     = (fill_q != '0);
        accept   = in_valid && in_ready;
        out_free = !out_valid_q || out_ready;
        hdr      = byte_buf_q[7:0];
        hdr9     = {1'b0, hdr};
        need9    = hdr9 + 9'd1;
        fill9    = 9'(fill_q);
        hdr_ok   = (hdr9 != 9'd0) && (hdr9 <= MAX_LEN_9);
        hdr_bad  = (hdr9 > MAX_LEN_9);
        ext_slot = run && have && out_free;
        do_pad   = ext_slot && (hdr9 == 9'd0);
        do_rec   = ext_slot && hdr_ok && (fill9 >= need9);
        do_bad   = ext_slot && hdr_bad;
        do_trunc = run && have && last_pend_q && hdr_ok && (fill9 < need9);
        rec_last = last_pend_q && (fill9 == need9) && !accept;
    end

    always_comb begin
        in_cnt  = '0;
        in_wide = '0;
        for (int unsigned i = 0; i < TKEEP_WIDTH; i++) begin
            in_cnt = in_cnt + FILL_W'(in_tkeep[i]);
            if (in_tkeep[i]) begin
                in_wide[i*8 +: 8] = in_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rec_data = '0;
        rec_keep = '0;
        for (int unsigned i = 0; i < TKEEP_WIDTH; i++) begin
            if (i < 32'(hdr)) begin
                rec_data[i*8 +: 8] = byte_buf_q[(i+1)*8 +: 8];
                rec_keep[i]        = 1'b1;
            end
        end
    end

    // Extraction shifts first; the accepted beat then lands at the post-shift fill.
    always_comb begin
        shift_amt = '0;
        if (do_pad) begin
            shift_amt = FILL_W'(1);
        end else if (do_rec) begin
            shift_amt = FILL_W'(need9);
        end
        buf_mid  = byte_buf_q >> {shift_amt, 3'b000};
        fill_mid = fill_q - shift_amt;
        if (do_bad || do_trunc) begin
            buf_mid  = '0;
            fill_mid = '0;
        end
        byte_buf_d = buf_mid;
        fill_d     = fill_mid;
        if (accept && run && !do_bad) begin
            byte_buf_d = buf_mid | (in_wide << {fill_mid, 3'b000});
            fill_d     = fill_mid + in_cnt;
        end
    end

    always_comb begin
        last_pend_d = last_pend_q;
        if (run && !have) begin
            last_pend_d = 1'b0;
        end
        if ((do_rec && rec_last) || do_bad || do_trunc) begin
            last_pend_d = 1'b0;
        end
        if (accept && run && !do_bad && in_tlast) begin
            last_pend_d = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        out_tkeep_d = out_tkeep_q;
        out_tlast_d = out_tlast_q;
        if (do_rec) begin
            out_valid_d = 1'b1;
            out_data_d  = rec_data;
            out_len_d   = LEN_WIDTH'(hdr);
            out_tkeep_d = rec_keep;
            out_tlast_d = rec_last;
        end
        err_d = do_bad || do_trunc;
    end

    // A bad header whose own beat carries tlast already closes the frame, so skip DROP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (do_bad && !last_pend_q && !(accept && in_tlast)) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (accept && in_tlast) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (reset) begin
            unique case (state_q)
                RUN:     in_ready = (fill_q <= MAX_LEN_F) && !(last_pend_q && (fill_q != '0));
                DROP:    in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_buf_q  <= '0;
            fill_q      <= '0;
            last_pend_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_tkeep_q <= '0;
            out_tlast_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            byte_buf_q  <= byte_buf_d;
            fill_q      <= fill_d;
            last_pend_q <= last_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
            out_tkeep_q <= out_tkeep_d;
            out_tlast_q <= out_tlast_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_len   = out_len_q;
    assign out_tkeep = out_tkeep_q;
    assign out_tlast = out_tlast_q;
    assign err       = err_q;

endmodule

// File: tb/tb_stream_unpacker.sv
// Scoreboard bench for stream_unpacker: records are queued as the byte
// stream is built and checked when the DUT hands them over.
module tb_stream_unpacker;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [31:0]  in_tkeep;
    logic         in_tlast;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [5:0]   out_len;
    logic [31:0]  out_tkeep;
    logic         out_tlast;
    logic         err;

    always #5 clk = ~clk;

    stream_unpacker #(
        .DATA_WIDTH (256),
        .TKEEP_WIDTH(32),
        .LEN_WIDTH  (6),
        .BUF_BYTES  (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tkeep (in_tkeep),
        .in_tlast (in_tlast),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_len  (out_len),
        .out_tkeep(out_tkeep),
        .out_tlast(out_tlast),
        .err      (err)
    );

    typedef struct {
        int           len;
        logic [255:0] data;
        bit           last;
    } rec_t;

    rec_t        sb[$];
    logic [7:0]  stream[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_cnt  = 0;
    int          out_cnt  = 0;
    bit          rnd_done;
    rec_t        mon_e;
    logic [31:0] mon_keep;

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (reset && out_valid && out_ready) begin
            out_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_record: got len=%0d data=%h, required no record", out_len, out_data);
            end else begin
                mon_e    = sb.pop_front();
                mon_keep = '0;
                for (int i = 0; i < mon_e.len; i++) mon_keep[i] = 1'b1;
                if (out_len !== 6'(mon_e.len) || out_data !== mon_e.data ||
                    out_tkeep !== mon_keep || out_tlast !== mon_e.last) begin
                    n_fail++;
                    $display("FAIL record: got len=%0d keep=%h last=%b data=%h, required len=%0d keep=%h last=%b data=%h",
                             out_len, out_tkeep, out_tlast, out_data, mon_e.len, mon_keep, mon_e.last, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_raw(input logic [7:0] b);
        stream.push_back(b);
    endtask

    task automatic push_rec(input int len, input logic [7:0] base, input logic [7:0] step, input bit last);
        rec_t       r;
        logic [7:0] b;
        r.len  = len;
        r.data = '0;
        r.last = last;
        stream.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i) * step;
            stream.push_back(b);
            r.data[i*8 +: 8] = b;
        end
        sb.push_back(r);
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input bit last);
        bit took;
        took     = 1'b0;
        in_data  = d;
        in_tkeep = k;
        in_tlast = last;
        in_valid = 1'b1;
        for (int c = 0; c < 300 && !took; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                took = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_tlast = 1'b0;
        n_checks++;
        if (!took) begin
            n_fail++;
            $display("FAIL beat_accept: got no acceptance within 300 cycles, required in_ready");
        end
    endtask

    task automatic send_frame();
        logic [255:0] d;
        logic [31:0]  k;
        int           n;
        while (stream.size() > 0) begin
            d = '0;
            k = '0;
            n = 0;
            while (stream.size() > 0 && n < 32) begin
                d[n*8 +: 8] = stream.pop_front();
                k[n] = 1'b1;
                n++;
            end
            send_beat(d, k, stream.size() == 0);
        end
    endtask

    task automatic drain(input int max_cycles);
        int c;
        c = 0;
        while (sb.size() > 0 && c < max_cycles) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d records pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_tlast, err, in_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b tlast=%b err=%b in_ready=%b, required all 0",
                     out_valid, out_tlast, err, in_ready);
        end
        n_checks++;
        if (out_data !== 256'd0 || out_len !== 6'd0 || out_tkeep !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h len=%0d keep=%h, required zeros", out_data, out_len, out_tkeep);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [255:0] junk;
        junk = {8{32'hDEADBEEF}};
        send_beat(junk, 32'h0, 1'b0);
        push_rec(3, 8'hA1, 8'h01, 1'b0);
        push_rec(27, 8'h55, 8'h00, 1'b1);
        send_frame();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: got out_valid=%b at accept edge, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_len !== 6'd3 || out_tkeep !== 32'h00000007 ||
            out_data[23:0] !== 24'hA3A2A1 || out_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_first: got v=%b len=%0d keep=%h data=%h last=%b, required 1/3/00000007/a3a2a1/0",
                     out_valid, out_len, out_tkeep, out_data[23:0], out_tlast);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_len !== 6'd27 || out_tkeep !== 32'h07FFFFFF || out_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_second: got v=%b len=%0d keep=%h last=%b, required 1/27/07ffffff/1",
                     out_valid, out_len, out_tkeep, out_tlast);
        end
        drain(50);
    endtask

    task automatic test_straddle();
        logic [255:0] exp32;
        bit           found;
        push_raw(8'h00);
        push_raw(8'h00);
        push_rec(17, 8'h10, 8'h01, 1'b0);
        push_rec(32, 8'hC0, 8'h03, 1'b1);
        exp32 = sb[$].data;
        send_frame();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_len == 6'd32) found = 1'b1;
        end
        n_checks++;
        if (!found || out_tkeep !== 32'hFFFFFFFF || out_data !== exp32 || out_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL straddle: got found=%b keep=%h last=%b data=%h, required 1/ffffffff/1/%h",
                     found, out_tkeep, out_tlast, out_data, exp32);
        end
        drain(50);
    endtask

    task automatic test_backpressure();
        logic [255:0] exp1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_rec(20, 8'h01, 8'h01, 1'b0);
        push_rec(20, 8'h40, 8'h01, 1'b0);
        push_rec(20, 8'h80, 8'h01, 1'b0);
        push_rec(1, 8'hEE, 8'h00, 1'b1);
        exp1 = sb[0].data;
        fork
            send_frame();
            begin
                repeat (4) @(negedge clk);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_valid !== 1'b1 || out_len !== 6'd20 || out_data !== exp1 || in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL hold_cycle%0d: got v=%b len=%0d in_ready=%b data=%h, required 1/20/0/%h",
                                 c, out_valid, out_len, in_ready, out_data, exp1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(100);
    endtask

    task automatic test_bad_header();
        int e0;
        e0 = err_cnt;
        push_rec(5, 8'h30, 8'h01, 1'b0);
        push_raw(8'h21);
        for (int i = 0; i < 121; i++) push_raw((i % 2 == 0) ? 8'h01 : 8'hEE);
        send_frame();
        drain(100);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL bad_header_err: got %0d err pulses, required 1", err_cnt - e0);
        end
        push_rec(4, 8'h11, 8'h05, 1'b0);
        push_rec(9, 8'h70, 8'h02, 1'b1);
        send_frame();
        drain(100);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL after_drop_err: got %0d err pulses, required 1", err_cnt - e0);
        end
    endtask

    task automatic test_truncation();
        int e0;
        int o0;
        e0 = err_cnt;
        push_rec(3, 8'h61, 8'h01, 1'b0);
        push_raw(8'h05);
        push_raw(8'hAA);
        push_raw(8'hBB);
        o0 = out_cnt;
        send_frame();
        drain(50);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt - e0 !== 1 || out_cnt - o0 !== 1) begin
            n_fail++;
            $display("FAIL truncation: got err=%0d records=%0d, required 1/1", err_cnt - e0, out_cnt - o0);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL truncation_idle: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        push_rec(2, 8'h90, 8'h01, 1'b1);
        send_frame();
        drain(50);
    endtask

    task automatic test_reset_mid();
        int o0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_rec(4, 8'h21, 8'h01, 1'b0);
        push_rec(6, 8'h31, 8'h01, 1'b0);
        push_rec(2, 8'h41, 8'h01, 1'b1);
        send_frame();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_len !== 6'd4) begin
            n_fail++;
            $display("FAIL pre_reset: got v=%b len=%0d, required 1/4", out_valid, out_len);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_tlast, err, in_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b tlast=%b err=%b in_ready=%b, required all 0",
                     out_valid, out_tlast, err, in_ready);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        o0 = out_cnt;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (out_cnt !== o0) begin
            n_fail++;
            $display("FAIL stale_record: got %0d records, required 0", out_cnt - o0);
        end
        push_rec(7, 8'h05, 8'h07, 1'b0);
        push_rec(1, 8'hF0, 8'h00, 1'b1);
        send_frame();
        drain(50);
    endtask

    task automatic test_back_to_back();
        int nrec;
        int len;
        int npad;
        @(posedge clk);
        #1;
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    nrec = $urandom_range(1, 5);
                    for (int r = 0; r < nrec; r++) begin
                        npad = $urandom_range(0, 2);
                        repeat (npad) push_raw(8'h00);
                        len = $urandom_range(1, 32);
                        push_rec(len, 8'($urandom), 8'($urandom_range(1, 255)), r == nrec - 1);
                    end
                    send_frame();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain(3000);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tkeep  = '0;
        in_tlast  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_straddle();
        test_backpressure();
        test_bad_header();
        test_truncation();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
